// File: rtl/axis_pkt_fifo.sv
// axis_pkt_fifo: AXI-Stream style synchronous FIFO with first-word fall-through
// and an optional store-and-forward packet mode.
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous, active-high; clears pointers, level, packet count
//   flush        synchronous clear of contents; reset takes priority
//   in_data      write payload (DATA_WIDTH)
//   in_last      end-of-packet marker stored alongside the payload
//   in_valid     write request
//   in_ready     space available (level < DEPTH)
//   out_data     head payload, presented combinationally
//   out_last     head end-of-packet marker
//   out_valid    head entry presentable
//   out_ready    consumer accept
//   level        stored entry count, 0..DEPTH
//   almost_full  level >= AF_THRESH
//   almost_empty level <= AE_THRESH
//
// Build option
//   AXIS_PKT_FIFO_PACKET_MODE_EN  when defined, out_valid is held off until a
//   complete packet is stored, except when the FIFO is full (cut-through
//   fallback so an oversize packet cannot deadlock the queue).

module axis_pkt_fifo #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned AF_THRESH  = DEPTH - 2,
  parameter int unsigned AE_THRESH  = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic [DATA_WIDTH-1:0]   in_data,
  input  logic                    in_last,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic                    out_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    almost_full,
  output logic                    almost_empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  typedef struct packed {
    logic                  last;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  entry_t          mem [DEPTH];
  entry_t          head;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [LW-1:0]   level_q;
  logic            clear;
  logic            wr_en;
  logic            rd_en;

  // Reset and flush have identical effect on state; reset simply wins when both are high.
  assign clear = reset || flush;

  // Handshakes; a full FIFO never passes a word through, even while being read.
  assign wr_en = in_valid && in_ready;
  assign rd_en = out_valid && out_ready;

  // Status flags derived from the level register only.
  assign in_ready     = (level_q < LW'(DEPTH));
  assign almost_full  = (level_q >= LW'(AF_THRESH));
  assign almost_empty = (level_q <= LW'(AE_THRESH));
  assign level        = level_q;

  // First-word fall-through head.
  assign head     = mem[rd_ptr];
  assign out_data = head.data;
  assign out_last = head.last;

  // Pointer and level bookkeeping; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (clear) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      if (wr_en && !rd_en) begin
        level_q <= level_q + LW'(1);
      end else if (rd_en && !wr_en) begin
        level_q <= level_q - LW'(1);
      end
    end
  end

  // Storage is not reset; a cleared level makes stale entries invisible.
  always_ff @(posedge clk) begin
    if (wr_en && !clear) begin
      mem[wr_ptr] <= '{last: in_last, data: in_data};
    end
  end

`ifdef AXIS_PKT_FIFO_PACKET_MODE_EN
  logic [LW-1:0] pkt_count;
  logic          pkt_inc;
  logic          pkt_dec;

  assign pkt_inc = wr_en && in_last;
  assign pkt_dec = rd_en && out_last;

  // Count of complete packets currently held.
  always_ff @(posedge clk) begin
    if (clear) begin
      pkt_count <= '0;
    end else if (pkt_inc && !pkt_dec) begin
      pkt_count <= pkt_count + LW'(1);
    end else if (pkt_dec && !pkt_inc) begin
      pkt_count <= pkt_count - LW'(1);
    end
  end

  // Hold the head until a whole packet is present, or the FIFO is full.
  assign out_valid = (level_q != '0) &&
                     ((pkt_count != '0) || (level_q == LW'(DEPTH)));
`else
  assign out_valid = (level_q != '0);
`endif

endmodule

// File: tb/tb_axis_pkt_fifo.sv
// Self-checking bench for axis_pkt_fifo: table-driven fill/full vectors, a
// reference model with a scoreboard queue for data ordering, and hand-written
// sequences for flush, mid-operation reset and (when built with the macro)
// packet mode.

module tb_axis_pkt_fifo;

  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned LW    = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          flush;
  logic [DW-1:0] in_data;
  logic          in_last;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          out_valid;
  logic          out_ready;
  logic [LW-1:0] level;
  logic          almost_full;
  logic          almost_empty;

  always #5 clk = ~clk;

  axis_pkt_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .in_data      (in_data),
    .in_last      (in_last),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .out_data     (out_data),
    .out_last     (out_last),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .level        (level),
    .almost_full  (almost_full),
    .almost_empty (almost_empty)
  );

  typedef struct packed {
    logic          last;
    logic [DW-1:0] data;
  } ent_t;

  typedef struct {
    logic          iv;
    logic [DW-1:0] d;
    logic          l;
    logic          ordy;
    int unsigned   exp_level;
    logic          exp_in_ready;
    logic          exp_af;
    logic          exp_ae;
  } vec_t;

  ent_t        sb[$];
  int unsigned m_level = 0;
  int unsigned m_pkt   = 0;
  int          n_cmp   = 0;
  int          n_bad   = 0;
  vec_t        tv[17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic m_out_valid();
`ifdef AXIS_PKT_FIFO_PACKET_MODE_EN
    return (m_level != 0) && ((m_pkt != 0) || (m_level == DEPTH));
`else
    return (m_level != 0);
`endif
  endfunction

  // One clock: drive, check head against scoreboard, clock, update model, check status.
  task automatic step(input logic iv, input logic [DW-1:0] d, input logic l,
                      input logic ordy, input logic fl, input logic rs);
    logic wr;
    logic rd;
    in_valid  = iv;
    in_data   = d;
    in_last   = l;
    out_ready = ordy;
    flush     = fl;
    reset     = rs;
    #1;
    chk("out_valid", 32'(out_valid), 32'(m_out_valid()));
    if (m_out_valid()) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL scoreboard: model valid with empty queue at %0t", $time);
      end else begin
        chk("out_data", out_data, sb[0].data);
        chk("out_last", 32'(out_last), 32'(sb[0].last));
      end
    end
    wr = iv && (m_level < DEPTH);
    rd = ordy && m_out_valid();
    @(posedge clk);
    if (rs || fl) begin
      sb.delete();
      m_level = 0;
      m_pkt   = 0;
    end else begin
      if (rd && sb.size() != 0) begin
        if (sb[0].last && m_pkt != 0) m_pkt--;
        void'(sb.pop_front());
      end
      if (wr) begin
        sb.push_back('{last: l, data: d});
        if (l) m_pkt++;
      end
      if (wr && !rd) m_level++;
      else if (rd && !wr) m_level--;
    end
    @(negedge clk);
    chk("level", 32'(level), m_level);
    chk("in_ready", 32'(in_ready), 32'(m_level < DEPTH));
    chk("almost_full", 32'(almost_full), 32'(m_level >= DEPTH - 2));
    chk("almost_empty", 32'(almost_empty), 32'(m_level <= 2));
  endtask

  initial begin
    // Fill to full with out_ready low, then one cycle of write+read while full.
    for (int i = 0; i < 16; i++) begin
      tv[i] = '{1'b1, DW'(i), (i % 5 == 4), 1'b0, i + 1, (i + 1 < 16), (i + 1 >= 14), (i + 1 <= 2)};
    end
    tv[16] = '{1'b1, 32'h0000_00AA, 1'b0, 1'b1, 15, 1'b1, 1'b1, 1'b0};

    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
    reset     = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_level", 32'(level), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_almost_empty", 32'(almost_empty), 1);
    chk("rst_almost_full", 32'(almost_full), 0);

    for (int i = 0; i < 17; i++) begin
      step(tv[i].iv, tv[i].d, tv[i].l, tv[i].ordy, 1'b0, 1'b0);
      chk("tbl_level", 32'(level), tv[i].exp_level);
      chk("tbl_in_ready", 32'(in_ready), 32'(tv[i].exp_in_ready));
      chk("tbl_almost_full", 32'(almost_full), 32'(tv[i].exp_af));
      chk("tbl_almost_empty", 32'(almost_empty), 32'(tv[i].exp_ae));
    end
    chk("full_head_after_read", out_data, 32'h0000_0001);

    // Drain to level 8, then stream 40 cycles of concurrent write and read.
    for (int i = 0; i < 7; i++) step(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("level_8", 32'(level), 8);
    for (int i = 0; i < 40; i++) begin
      step(1'b1, DW'(32'h100 + i), (i % 7 == 6), 1'b1, 1'b0, 1'b0);
      chk("stream_level", 32'(level), 8);
    end

    // Flush at level 5 together with a write; the written word must vanish.
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("level_5", 32'(level), 5);
    step(1'b1, 32'h0000_DEAD, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("flush_level", 32'(level), 0);
    chk("flush_out_valid", 32'(out_valid), 0);
    step(1'b1, 32'h0000_0055, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("post_flush_valid", 32'(out_valid), 1);
    chk("post_flush_head", out_data, 32'h0000_0055);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Reset mid-operation, with flush and a write also requested.
    for (int i = 0; i < 3; i++) step(1'b1, DW'(32'h200 + i), 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h0000_BEEF, 1'b1, 1'b1, 1'b1, 1'b1);
    chk("midrst_level", 32'(level), 0);
    chk("midrst_out_valid", 32'(out_valid), 0);
    step(1'b1, 32'h0000_0301, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h0000_0302, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("postrst_head", out_data, 32'h0000_0301);
    for (int i = 0; i < 2; i++) step(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("postrst_empty", 32'(level), 0);

`ifdef AXIS_PKT_FIFO_PACKET_MODE_EN
    // Three-word packet is held until its last word lands.
    step(1'b1, 32'h0000_00A1, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("pkt3_hold1", 32'(out_valid), 0);
    step(1'b1, 32'h0000_00A2, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("pkt3_hold2", 32'(out_valid), 0);
    step(1'b1, 32'h0000_00A3, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("pkt3_release", 32'(out_valid), 1);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("pkt3_empty", 32'(level), 0);

    // Oversize packet: cut-through only at full, then completed by its last word.
    for (int i = 0; i < 16; i++) step(1'b1, DW'(32'hB0 + i), 1'b0, 1'b0, 1'b0, 1'b0);
    chk("big_full_valid", 32'(out_valid), 1);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("big_15_valid", 32'(out_valid), 0);
    step(1'b1, 32'h0000_00FF, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) step(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("big_drained", 32'(level), 0);
    chk("big_pkt_count", 32'(dut.pkt_count), 0);
`endif

    step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/axis_pkt_fifo.md
AXIS_PKT_FIFO -- requirements
Module: axis_pkt_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: payload width in bits.
REQ-002 SHALL have parameter DEPTH, default 16: entry count; power of two, at least 2.
REQ-003 SHALL have parameter AF_THRESH, default DEPTH-2: almost_full asserts at level >= AF_THRESH.
REQ-004 SHALL have parameter AE_THRESH, default 2: almost_empty asserts at level <= AE_THRESH.
REQ-005 SHALL have port clk, input, 1: rising-edge clock.
REQ-006 SHALL have port reset, input, 1: reset, synchronous, active-high.
REQ-007 SHALL have port flush, input, 1: synchronous clear of contents, same cycle semantics as reset.
REQ-008 SHALL have port in_data, input, DATA_WIDTH: write payload.
REQ-009 SHALL have port in_last, input, 1: end-of-packet marker stored with the payload.
REQ-010 SHALL have port in_valid, input, 1: write request.
REQ-011 SHALL have port in_ready, output, 1: space available.
REQ-012 SHALL have port out_data, output, DATA_WIDTH: head payload, first-word fall-through.
REQ-013 SHALL have port out_last, output, 1: head end-of-packet marker.
REQ-014 SHALL have port out_valid, output, 1: head entry presentable.
REQ-015 SHALL have port out_ready, input, 1: consumer accept.
REQ-016 SHALL have port level, output, clog2(DEPTH)+1: stored entry count, 0..DEPTH.
REQ-017 SHALL have port almost_full, output, 1: level >= AF_THRESH.
REQ-018 SHALL have port almost_empty, output, 1: level <= AE_THRESH.

Function
REQ-019 SHALL write on in_valid&&in_ready; in_ready = (level < DEPTH), with no pass-through when full even if out_ready is high.
REQ-020 SHALL read on out_valid&&out_ready and advance the read pointer by one.
REQ-021 SHALL update level as +1 on write only, -1 on read only, and leave it unchanged on a simultaneous write and read.
REQ-022 SHALL let pointers wrap modulo DEPTH, with no lost or duplicated entries across the wrap.
REQ-023 SHALL present out_data/out_last combinationally from the head entry, with write-to-out_valid latency of 1 cycle.
REQ-024 SHALL derive almost_full, almost_empty and in_ready combinationally from the level register.
REQ-025 SHALL, when flush is asserted, leave level 0 and pointers 0 next cycle; writes and reads presented in that cycle are discarded; flush has priority over handshakes.
REQ-026 SHALL leave out_data/out_last don't-care when out_valid=0.

Reset
REQ-027 SHALL, while reset is asserted, leave next cycle: level=0, wr/rd pointers=0, pkt_count=0, out_valid=0, in_ready=1, almost_empty=1, almost_full=0.
REQ-028 SHALL, on reset mid-operation, discard stored data without requiring memory contents to be cleared; reset has priority over flush.

Configuration
REQ-029 SHALL, with macro AXIS_PKT_FIFO_PACKET_MODE_EN defined, keep pkt_count (width clog2(DEPTH)+1) of complete packets stored: +1 on a write with in_last, -1 on a read with out_last, unchanged when both occur.
REQ-030 SHALL, in packet mode, set out_valid = (level != 0) && ((pkt_count != 0) || (level == DEPTH)); the full-FIFO term is the oversize-packet cut-through fallback that prevents deadlock.
REQ-031 SHALL, without the macro, omit pkt_count and set out_valid = (level != 0); in_last is stored and forwarded only.

Verification
REQ-032 SHALL cover: reset, then 16 writes 0x00..0x0F with out_ready=0 -> in_ready=0 after the 16th, level=16, almost_full=1 from level 14, out_data=0x00.
REQ-033 SHALL cover: full FIFO with in_valid=1 and out_ready=1 for one cycle -> read of 0x00 only, no write, level=15, in_ready=1.
REQ-034 SHALL cover: level=8 with continuous write and read for 40 cycles -> level stays 8, output order exact across 5 pointer wraps.
REQ-035 SHALL cover: flush at level=5 with a simultaneous write -> level=0, out_valid=0 next cycle, written word not retained.
REQ-036 SHALL cover packet mode: 3 words, last on the 3rd -> out_valid=0 until the cycle after the 3rd write, then 3 reads with out_last on the 3rd.
REQ-037 SHALL cover packet mode: 16 words without in_last -> out_valid=1 at level=16; draining all 16 completes with pkt_count=0.
